// File: rtl/serial_frame_rx_pkg.sv
// Shared definitions for the serial frame receiver: FSM state encodings and
// the default frame format (sync pattern, payload and counter widths), so the
// receiver and the matching generator agree on one description of a frame.
// Optional feature macro: SFRX_PARITY_CHECK_EN (one even-parity bit after payload).
package serial_frame_rx_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2
  } sfrx_state_e;

  localparam int         SFRX_SYNC_W   = 8;
  localparam logic [7:0] SFRX_SYNC_PAT = 8'hA7;
  localparam int         SFRX_DATA_W   = 8;
  localparam int         SFRX_CNT_W    = 8;

endpackage

// File: rtl/serial_frame_rx_if.sv
// Serial line plus received-word bundle between the bit source (master) and
// the frame receiver (slave).
interface serial_frame_rx_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);
  logic              din;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              parity_err;
  logic              busy;
  logic [CNT_W-1:0]  frame_cnt;

  modport master (
    output din,
    input  data_out, data_valid, parity_err, busy, frame_cnt
  );

  modport slave (
    input  din,
    output data_out, data_valid, parity_err, busy, frame_cnt
  );
endinterface

// File: rtl/sfrx_sync_detect.sv
// Sync hunter: keeps the recent line history and flags when that history plus
// the bit currently on the line equals the sync pattern. Only the newest
// SYNC_W-1 bits are stored, since the oldest bit of a full window can never
// take part in a future comparison.
module sfrx_sync_detect #(
  parameter int              SYNC_W   = 8,
  parameter logic [SYNC_W-1:0] SYNC_PAT = 8'hA7
) (
  input  logic clk,
  input  logic rst,
  input  logic shift_en_i,
  input  logic clr_i,
  input  logic din_i,
  output logic match_o
);

  logic [SYNC_W-2:0] hist_q, hist_d;
  logic [SYNC_W-1:0] window;

  assign window  = {hist_q, din_i};
  assign match_o = shift_en_i && (window == SYNC_PAT);

  // Next history: clear after a frame so stale bits never complete a match.
  always_comb begin
    hist_d = hist_q;
    if (clr_i) begin
      hist_d = '0;
    end else if (shift_en_i) begin
      hist_d = window[SYNC_W-2:0];
    end
  end

  // History register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: hunts for the sync pattern, shifts in one payload
// word MSB-first, optionally checks one even-parity bit, then presents the
// word with a one-cycle valid strobe one cycle after the final bit.
// Optional feature macro: SFRX_PARITY_CHECK_EN.
module serial_frame_rx
  import serial_frame_rx_pkg::*;
#(
  parameter int                SYNC_W   = SFRX_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_PAT = SFRX_SYNC_PAT,
  parameter int                DATA_W   = SFRX_DATA_W,
  parameter int                CNT_W    = SFRX_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  serial_frame_rx_if.slave bus
);

  localparam int              BC_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);

  sfrx_state_e       state_q, state_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] payload_q, payload_d;
  logic              done_q;
  logic [DATA_W-1:0] data_out_q;
  logic              data_valid_q;
  logic [CNT_W-1:0]  frame_cnt_q;

  logic sync_match;
  logic hunt_en;
  logic shift_en;
  logic frame_end;
  logic busy;
  logic last_bit;

  assign last_bit = (bit_cnt_q == LAST_BIT);

  sfrx_sync_detect #(
    .SYNC_W   (SYNC_W),
    .SYNC_PAT (SYNC_PAT)
  ) u_sync_detect (
    .clk        (clk),
    .rst        (rst),
    .shift_en_i (hunt_en),
    .clr_i      (frame_end),
    .din_i      (bus.din),
    .match_o    (sync_match)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: HUNT -> DATA on sync, DATA -> (PARITY) -> HUNT.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_HUNT: begin
        if (sync_match) state_d = ST_DATA;
      end
      ST_DATA: begin
`ifdef SFRX_PARITY_CHECK_EN
        if (last_bit) state_d = ST_PARITY;
`else
        if (last_bit) state_d = ST_HUNT;
`endif
      end
`ifdef SFRX_PARITY_CHECK_EN
      ST_PARITY: state_d = ST_HUNT;
`endif
      default: state_d = ST_HUNT;
    endcase
  end

`ifdef SFRX_PARITY_CHECK_EN
  logic par_en;
`endif

  // FSM outputs: which datapath element samples the line this cycle.
  always_comb begin
    hunt_en   = 1'b0;
    shift_en  = 1'b0;
    frame_end = 1'b0;
    busy      = 1'b0;
`ifdef SFRX_PARITY_CHECK_EN
    par_en    = 1'b0;
`endif
    unique case (state_q)
      ST_HUNT: hunt_en = 1'b1;
      ST_DATA: begin
        shift_en = 1'b1;
        busy     = 1'b1;
`ifndef SFRX_PARITY_CHECK_EN
        frame_end = last_bit;
`endif
      end
`ifdef SFRX_PARITY_CHECK_EN
      ST_PARITY: begin
        par_en    = 1'b1;
        busy      = 1'b1;
        frame_end = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Payload shifter and bit counter next values; counter rests at 0 outside DATA.
  always_comb begin
    bit_cnt_d = shift_en ? (bit_cnt_q + BC_W'(1)) : '0;
    payload_d = shift_en ? {payload_q[DATA_W-2:0], bus.din} : payload_q;
  end

  // Payload, bit counter and final-bit marker registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q <= '0;
      payload_q <= '0;
      done_q    <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      payload_q <= payload_d;
      done_q    <= frame_end;
    end
  end

  // Frame completion: publish word, strobe valid, bump the wrapping counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_valid_q <= 1'b0;
      data_out_q   <= '0;
      frame_cnt_q  <= '0;
    end else begin
      data_valid_q <= done_q;
      if (done_q) begin
        data_out_q  <= payload_q;
        frame_cnt_q <= frame_cnt_q + CNT_W'(1);
      end
    end
  end

`ifdef SFRX_PARITY_CHECK_EN
  logic par_bit_q;
  logic parity_err_q;

  // Capture the parity bit and flag an even-parity mismatch at completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      if (par_en) par_bit_q <= bus.din;
      if (done_q) parity_err_q <= ((^payload_q) != par_bit_q);
    end
  end

  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.busy       = busy;
  assign bus.frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: bit streams are built as queues, a stream-scanning
// reference model derives the expected per-cycle outputs, and every cycle of
// every segment is compared against it.
module tb_serial_frame_rx;

  localparam int         DW   = 8;
  localparam logic [7:0] SYNC = 8'hA7;
`ifdef SFRX_PARITY_CHECK_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  // bits following the last sync bit that belong to the frame
  localparam int TAIL = DW + PAR;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #15 clk = ~clk;

  serial_frame_rx_if #(.DATA_W(8), .CNT_W(8)) bus ();

  serial_frame_rx #(
    .SYNC_W   (8),
    .SYNC_PAT (8'hA7),
    .DATA_W   (8),
    .CNT_W    (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int strobes  = 0;

  bit         stim[$];
  bit         ev[$];
  bit         eb[$];
  logic [7:0] ed[$];
  bit         ep[$];

  int         m_cnt  = 0;
  logic [7:0] m_data = '0;
  bit         m_perr = 1'b0;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_data = '0;
    m_perr = 1'b0;
  endtask

  task automatic push_byte(logic [7:0] b);
    for (int k = 7; k >= 0; k--) stim.push_back(b[k]);
  endtask

  task automatic push_frame(logic [7:0] pay, bit p);
    push_byte(SYNC);
    push_byte(pay);
    if (PAR == 1) stim.push_back(p);
  endtask

  task automatic push_idle(int n);
    repeat (n) stim.push_back(1'b0);
  endtask

  // Scan the stream as the frame format describes it: a sync window built from
  // bits seen since the last frame (zeros before), then payload, then parity.
  task automatic build_expect();
    int         n;
    int         i;
    logic [7:0] win;
    n = stim.size();
    ev.delete(); eb.delete(); ed.delete(); ep.delete();
    for (int k = 0; k < n; k++) begin
      ev.push_back(1'b0); eb.push_back(1'b0); ed.push_back('0); ep.push_back(1'b0);
    end
    win = '0;
    i   = 0;
    while (i < n) begin
      win = {win[6:0], stim[i]};
      if (win == SYNC) begin
        for (int k = i; k < i + TAIL && k < n; k++) eb[k] = 1'b1;
        if (i + TAIL + 1 < n) begin
          logic [7:0] pay;
          bit         p;
          pay = '0;
          for (int k = 1; k <= DW; k++) pay = {pay[6:0], stim[i + k]};
          p = (PAR == 1) ? stim[i + DW + 1] : 1'b0;
          ev[i + TAIL + 1] = 1'b1;
          ed[i + TAIL + 1] = pay;
          ep[i + TAIL + 1] = (PAR == 1) && ((^pay) != p);
        end
        i   = i + TAIL + 1;
        win = '0;
      end else begin
        i++;
      end
    end
  endtask

  // Drive one queued bit per clock (entered at a falling edge) and compare
  // every output after each rising edge.
  task automatic run_seg(string name);
    build_expect();
    for (int j = 0; j < stim.size(); j++) begin
      bus.din = stim[j];
      @(negedge clk);
      if (ev[j]) begin
        m_cnt++;
        m_data = ed[j];
        m_perr = ep[j];
        $display("rx %s: frame %0d data=%02h perr=%0b", name, m_cnt, m_data, m_perr);
      end
      if (bus.data_valid === 1'b1) strobes++;
      check_eq({name, ".valid"}, 32'(bus.data_valid), 32'(ev[j]));
      check_eq({name, ".busy"},  32'(bus.busy),       32'(eb[j]));
      check_eq({name, ".data"},  32'(bus.data_out),   32'(m_data));
      check_eq({name, ".perr"},  32'(bus.parity_err), 32'(m_perr));
      check_eq({name, ".cnt"},   32'(bus.frame_cnt),  32'(m_cnt % 256));
    end
    stim.delete();
  endtask

  task automatic check_all_zero(string tag);
    check_eq({tag, ".valid"}, 32'(bus.data_valid), 32'd0);
    check_eq({tag, ".busy"},  32'(bus.busy),       32'd0);
    check_eq({tag, ".data"},  32'(bus.data_out),   32'd0);
    check_eq({tag, ".perr"},  32'(bus.parity_err), 32'd0);
    check_eq({tag, ".cnt"},   32'(bus.frame_cnt),  32'd0);
  endtask

  initial begin
    bus.din = 1'b0;
    rst     = 1'b1;

    // reset held while the line toggles
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      bus.din = k[0];
      @(negedge clk);
      check_all_zero("reset");
    end
    rst = 1'b0;
    model_reset();
    push_idle(20);
    run_seg("idle");

    // good frame 3C
    push_frame(8'h3C, 1'b0);
    push_idle(12);
    run_seg("good3C");
    check_eq("good3C.final_data", 32'(bus.data_out), 32'h3C);

    // 3C with a wrong parity bit
    push_frame(8'h3C, 1'b1);
    push_idle(12);
    run_seg("bad3C");

    // sync pattern as payload, then 55 which must not start a frame
    push_frame(8'hA7, 1'b1);
    push_byte(8'h55);
    push_idle(12);
    run_seg("syncpay");
    check_eq("syncpay.final_data", 32'(bus.data_out), 32'hA7);

    // reset in the middle of a payload
    push_byte(SYNC);
    stim.push_back(1'b1); stim.push_back(1'b0); stim.push_back(1'b1); stim.push_back(1'b1);
    run_seg("partial");
    #5 rst = 1'b1;
    #1 check_all_zero("midrst");
    @(negedge clk);
    check_all_zero("midrst_hold");
    rst = 1'b0;
    model_reset();
    push_frame(8'h81, 1'b0);
    push_idle(12);
    run_seg("after_rst");
    check_eq("after_rst.final_data", 32'(bus.data_out), 32'h81);

    // 256 back-to-back good frames wrap the counter
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    strobes = 0;
    for (int f = 0; f < 256; f++) begin
      logic [7:0] pay;
      pay = 8'($urandom);
      push_frame(pay, ^pay);
    end
    push_idle(12);
    run_seg("b2b");
    check_eq("b2b.strobes", 32'(strobes), 32'd256);
    check_eq("b2b.wrap", 32'(bus.frame_cnt), 32'd0);

    // random noise with interleaved frames and random parity
    for (int r = 0; r < 40; r++) begin
      repeat ($urandom_range(0, 20)) stim.push_back(1'($urandom));
      push_frame(8'($urandom), 1'($urandom));
    end
    push_idle(12);
    run_seg("noise");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
